// File: rtl/da2_frame_driver_if.sv
// da2_frame_driver_if: sample-set handshake bundle feeding da2_frame_driver
interface da2_frame_driver_if #(
   parameter int N_CH = 2,
   parameter int IN_W = 16
);
   logic [N_CH*IN_W-1:0] sig_in;
   logic [N_CH*IN_W-1:0] shift_in;
   logic [3:0]           gain_shift;
   logic                 in_valid;
   logic                 in_ready;
   modport master (output sig_in, shift_in, gain_shift, in_valid, input in_ready);
   modport slave (input sig_in, shift_in, gain_shift, in_valid, output in_ready);
endinterface

// File: rtl/da2_frame_driver.sv
// da2_frame_driver: N-channel offset/gain/clamp DAC stage with DAC121S101-style serial frames.
// Define DA2_SATURATE_EN to clamp codes to the DAC range; otherwise codes wrap (legacy).
module da2_frame_driver #(
   parameter int N_CH    = 2,
   parameter int IN_W    = 16,
   parameter int DAC_W   = 12,
   parameter int CLK_DIV = 2
) (
   input  logic             clk_100,
   input  logic             reset_n,
   da2_frame_driver_if.slave bus,
   output logic             busy,
   output logic             done,
   output logic [N_CH-1:0]  sat_flag,
   output logic             dac_sync_n,
   output logic             dac_sclk,
   output logic [N_CH-1:0]  dac_d
);
   localparam int SW = IN_W + 16;
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic signed [SW-1:0] HI = SW'((1 << (DAC_W - 1)) - 1);
   localparam logic signed [SW-1:0] LO = ~HI;
   typedef enum logic [2:0] {IDLE, P1, P2, P3, SHIFT, GAP} state_t;
   state_t state;
   logic [IN_W-1:0]      sig_r [N_CH];
   logic [IN_W-1:0]      off_r [N_CH];
   logic [3:0]           gain_r;
   logic [IN_W:0]        d [N_CH];
   logic signed [SW-1:0] s [N_CH];
   logic signed [SW-1:0] c [N_CH];
   logic [N_CH-1:0]      clip;
   logic [15:0]          sreg [N_CH];
   logic [CW-1:0]        ph;
   logic [4:0]           nbit;
   // limit each shifted sample to the DAC range, or pass it through for wrap-around codes
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
`ifdef DA2_SATURATE_EN
         clip[k] = (s[k] > HI) || (s[k] < LO);
         c[k] = (s[k] > HI) ? HI : (s[k] < LO) ? LO : s[k];
`else
         clip[k] = 1'b0;
         c[k] = s[k];
`endif
      end
   end
   // frame sequencer: latch, three arithmetic stages, 16-bit shift-out, then a short gap
   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         bus.in_ready <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         sat_flag <= '0;
         dac_sync_n <= 1'b1;
         dac_sclk <= 1'b1;
         dac_d <= '0;
         gain_r <= '0;
         ph <= '0;
         nbit <= '0;
         for (int k = 0; k < N_CH; k++) begin
            sig_r[k] <= '0;
            off_r[k] <= '0;
            d[k] <= '0;
            s[k] <= '0;
            sreg[k] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               bus.in_ready <= 1'b1;
               if (bus.in_valid && bus.in_ready) begin
                  for (int k = 0; k < N_CH; k++) begin
                     sig_r[k] <= bus.sig_in[k*IN_W +: IN_W];
                     off_r[k] <= bus.shift_in[k*IN_W +: IN_W];
                  end
                  gain_r <= bus.gain_shift;
                  bus.in_ready <= 1'b0;
                  busy <= 1'b1;
                  state <= P1;
               end
            end
            P1: begin
               for (int k = 0; k < N_CH; k++)
                  d[k] <= {sig_r[k][IN_W-1], sig_r[k]} - {off_r[k][IN_W-1], off_r[k]};
               state <= P2;
            end
            P2: begin
               for (int k = 0; k < N_CH; k++)
                  s[k] <= {{15{d[k][IN_W]}}, d[k]} << gain_r;
               state <= P3;
            end
            P3: begin
               sat_flag <= clip;
               for (int k = 0; k < N_CH; k++)
                  sreg[k] <= 16'({~c[k][DAC_W-1], c[k][DAC_W-2:0]});
               ph <= '0;
               nbit <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               if (nbit == 5'd16) begin
                  dac_sync_n <= 1'b1;
                  dac_sclk <= 1'b1;
                  dac_d <= '0;
                  done <= 1'b1;
                  ph <= '0;
                  state <= GAP;
               end else begin
                  if (ph == '0) begin
                     dac_sync_n <= 1'b0;
                     dac_sclk <= 1'b1;
                     for (int k = 0; k < N_CH; k++) begin
                        dac_d[k] <= sreg[k][15];
                        sreg[k] <= sreg[k] << 1;
                     end
                  end
                  if (ph == CW'(CLK_DIV))
                     dac_sclk <= 1'b0;
                  ph <= (ph == CW'(2 * CLK_DIV - 1)) ? '0 : ph + 1'b1;
                  if (ph == CW'(2 * CLK_DIV - 1))
                     nbit <= nbit + 5'd1;
               end
            end
            GAP: begin
               if (ph == CW'(CLK_DIV - 1)) begin
                  busy <= 1'b0;
                  bus.in_ready <= 1'b1;
                  state <= IDLE;
               end else
                  ph <= ph + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_da2_frame_driver.sv
// tb_da2_frame_driver: randomized frames checked against an arithmetic DAC-code model
module tb_da2_frame_driver;
   localparam int N_CH = 2, IN_W = 16, DAC_W = 12, CLK_DIV = 2;
   localparam int T_SYNC = 4, T_DONE = 4 + 32 * CLK_DIV, T_RDY = 4 + 33 * CLK_DIV;
   logic clk_100 = 1'b0;
   logic reset_n = 1'b0;
   logic busy, done, dac_sync_n, dac_sclk;
   logic [N_CH-1:0] sat_flag, dac_d;
   int n_checks = 0, n_errors = 0;
   bit prev_held = 0;
   da2_frame_driver_if #(.N_CH(N_CH), .IN_W(IN_W)) bus ();
   da2_frame_driver #(.N_CH(N_CH), .IN_W(IN_W), .DAC_W(DAC_W), .CLK_DIV(CLK_DIV)) dut (
      .clk_100(clk_100),
      .reset_n(reset_n),
      .bus(bus),
      .busy(busy),
      .done(done),
      .sat_flag(sat_flag),
      .dac_sync_n(dac_sync_n),
      .dac_sclk(dac_sclk),
      .dac_d(dac_d)
   );
   always #5 clk_100 = ~clk_100;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   // expected 16-bit frame: (sig - off) * 2^g, optionally clamped, then offset-binary
   function automatic logic [15:0] ref_code(input int sig, input int off, input int g, output logic sat);
      longint v, hi, lo, half;
      half = longint'(1) << (DAC_W - 1);
      hi = half - 1;
      lo = -half;
      v = longint'(sig - off) * (longint'(1) << g);
      sat = 1'b0;
`ifdef DA2_SATURATE_EN
      if (v > hi) begin v = hi; sat = 1'b1; end
      else if (v < lo) begin v = lo; sat = 1'b1; end
`endif
      return 16'((v + half) & ((half << 1) - 1));
   endfunction
   task automatic rand_inputs();
      for (int k = 0; k < N_CH; k++) begin
         bus.sig_in[k*IN_W +: IN_W] = ($urandom_range(0, 1) != 0) ? IN_W'($urandom) : IN_W'($urandom_range(0, 255) - 128);
         bus.shift_in[k*IN_W +: IN_W] = ($urandom_range(0, 1) != 0) ? IN_W'($urandom) : IN_W'($urandom_range(0, 255) - 128);
      end
      bus.gain_shift = 4'($urandom);
   endtask
   task automatic frame(input bit hold, input bit scramble, input int g_next, input int abort_t, input string name);
      logic [15:0] exp_f [N_CH];
      logic [15:0] got_f [N_CH];
      logic [N_CH-1:0] exp_sat;
      logic sat_k, prev_sclk;
      int t, waited, sync_first, sync_len, done_t, done_cnt, rdy_t, nbits, busy_bad;
      waited = 0;
      while (!bus.in_ready && waited < 400) begin
         @(negedge clk_100);
         waited++;
      end
      if (prev_held) chk({name, " reaccept_wait"}, waited, 0);
      bus.in_valid = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
         exp_f[k] = ref_code(int'($signed(bus.sig_in[k*IN_W +: IN_W])), int'($signed(bus.shift_in[k*IN_W +: IN_W])), int'(bus.gain_shift), sat_k);
         exp_sat[k] = sat_k;
         got_f[k] = '0;
      end
      @(posedge clk_100);
      #1;
      chk({name, " accept"}, {bus.in_ready, busy}, 2'b01);
      if (!hold) bus.in_valid = 1'b0;
      if (scramble) rand_inputs();
      t = 0; sync_first = -1; sync_len = 0; done_t = -1; done_cnt = 0; rdy_t = -1; nbits = 0; busy_bad = 0;
      prev_sclk = 1'b1;
      while (t < T_RDY + 20) begin
         @(posedge clk_100);
         #1;
         t++;
         if (t == 1 && g_next >= 0) bus.gain_shift = 4'(g_next);
         if (t == abort_t) begin
            bus.in_valid = 1'b0;
            #2 reset_n = 1'b0;
            #1;
            chk({name, " abort_outs"}, {dac_sync_n, dac_sclk, done, busy, bus.in_ready}, 5'b11000);
            chk({name, " abort_d_sat"}, {dac_d, sat_flag}, '0);
            repeat (2) @(negedge clk_100);
            reset_n = 1'b1;
            @(posedge clk_100);
            #1;
            chk({name, " ready_after_release"}, bus.in_ready, 1);
            prev_held = 0;
            return;
         end
         if (!dac_sync_n) begin
            if (sync_first < 0) sync_first = t;
            sync_len++;
         end
         if (prev_sclk && !dac_sclk && !dac_sync_n) begin
            for (int k = 0; k < N_CH; k++) got_f[k] = {got_f[k][14:0], dac_d[k]};
            nbits++;
         end
         prev_sclk = dac_sclk;
         if (done) begin
            done_cnt++;
            done_t = t;
         end
         if (bus.in_ready) begin
            rdy_t = t;
            break;
         end
         if (!busy) busy_bad++;
      end
      chk({name, " sync_start"}, sync_first, T_SYNC);
      chk({name, " sync_len"}, sync_len, 32 * CLK_DIV);
      chk({name, " done_time"}, done_t, T_DONE);
      chk({name, " done_count"}, done_cnt, 1);
      chk({name, " ready_time"}, rdy_t, T_RDY);
      chk({name, " busy"}, {busy_bad, busy}, 0);
      chk({name, " nbits"}, nbits, 16);
      for (int k = 0; k < N_CH; k++) chk($sformatf("%s frame%0d", name, k), got_f[k], exp_f[k]);
      chk({name, " sat_flag"}, sat_flag, exp_sat);
      prev_held = hold;
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.sig_in = '0;
      bus.shift_in = '0;
      bus.gain_shift = '0;
      repeat (3) @(posedge clk_100);
      #1;
      chk("reset_outs", {bus.in_ready, busy, done, dac_sync_n, dac_sclk}, 5'b00011);
      chk("reset_d_sat", {dac_d, sat_flag}, '0);
      @(negedge clk_100);
      reset_n = 1'b1;
      @(posedge clk_100);
      #1;
      chk("ready_after_reset", bus.in_ready, 1);
      bus.sig_in = {16'h1234, 16'h0100};
      bus.shift_in = {16'h0034, 16'h0100};
      bus.gain_shift = 4'd0;
      frame(0, 1, -1, 0, "offset");
      bus.sig_in = {16'h0005, 16'h0800};
      bus.shift_in = {16'h0000, 16'h0100};
      bus.gain_shift = 4'd4;
      frame(0, 1, -1, 0, "gain");
      bus.sig_in = {16'h8000, 16'h7000};
      bus.shift_in = {16'h7FFF, 16'h0000};
      bus.gain_shift = 4'd0;
      frame(0, 0, -1, 0, "sat");
      rand_inputs();
      frame(1, 1, -1, 0, "hold0");
      frame(1, 1, -1, 0, "hold1");
      frame(0, 1, -1, 0, "hold2");
      for (int i = 0; i < 8; i++) begin
         rand_inputs();
         frame(1'($urandom), 1, -1, 0, $sformatf("rand%0d", i));
      end
      bus.in_valid = 1'b0;
      rand_inputs();
      frame(0, 1, -1, 33, "abort");
      rand_inputs();
      frame(0, 1, -1, 0, "after_abort");
      bus.sig_in = {16'h0010, 16'h0005};
      bus.shift_in = '0;
      bus.gain_shift = 4'd0;
      frame(1, 0, 3, 0, "gchg0");
      frame(0, 0, -1, 0, "gchg3");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
